// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: credit-limited imem requests, {pc, instr} FIFO to decode
package core_pkg;
  localparam int Xlen = 64;
  localparam int Ilen = 32;
endpackage

module fetch_unit
  import core_pkg::*;
#(
  parameter logic [Xlen-1:0] ResetPc = '0,
  parameter int              Depth   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [Xlen-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [Xlen-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [Ilen-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [Ilen-1:0] instr_o,
  output logic [Xlen-1:0] pc_o
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  localparam cnt_t            DepthC  = cnt_t'(Depth);
  localparam ptr_t            PtrLast = ptr_t'(Depth - 1);
  localparam logic [Xlen-1:0] PcStep  = 4;

  logic [Xlen-1:0] fetch_pc;
  logic [Xlen-1:0] rsp_pc;
  cnt_t            outstanding;
  cnt_t            drop;
  cnt_t            count;
  ptr_t            wr_ptr;
  ptr_t            rd_ptr;

  logic [Xlen-1:0] pc_mem    [Depth];
  logic [Ilen-1:0] instr_mem [Depth];

  logic [Xlen-1:0] redirect_tgt;
  logic [CntW:0]   credits_used;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            full;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrLast) ? '0 : p + ptr_t'(1);
  endfunction

  // Low two bits of a redirect target are forced to zero: fetches are word aligned.
  assign redirect_tgt = {redirect_pc_i[Xlen-1:2], 2'b00};

  // Every in-flight or buffered word holds one credit, so a response always has a FIFO slot.
  assign credits_used = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_valid_o = !rst_i && !redirect_valid_i && (credits_used < {1'b0, DepthC});
  assign imem_req_addr_o  = rst_i ? ResetPc : fetch_pc;

  assign instr_valid_o = (count != '0) && !redirect_valid_i;
  assign instr_o       = instr_mem[rd_ptr];
  assign pc_o          = pc_mem[rd_ptr];

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign push     = imem_rsp_valid_i && (drop == '0) && !redirect_valid_i;
  assign pop      = instr_valid_o && instr_ready_i;
  assign full     = (count == DepthC);

  // Control state: PCs, credit counters, stale-response drop counter and FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= ResetPc;
      rsp_pc      <= ResetPc;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid_i) begin
      // Everything still in flight belongs to the old stream, including a response landing now.
      fetch_pc    <= redirect_tgt;
      rsp_pc      <= redirect_tgt;
      outstanding <= outstanding - cnt_t'(imem_rsp_valid_i);
      drop        <= outstanding - cnt_t'(imem_rsp_valid_i);
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PcStep;
      end
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid_i);
      if (imem_rsp_valid_i && (drop != '0)) begin
        drop <= drop - cnt_t'(1);
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rsp_pc <= rsp_pc + PcStep;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // FIFO storage: cleared on reset so the head never shows X, written on every accepted response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data_i;
    end
  end

  // The credit limit must make overflow impossible.
  no_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import core_pkg::*;

  localparam int          Depth = 3;
  localparam logic [63:0] Rpc   = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  always #5 clk = ~clk;

  fetch_unit #(.ResetPc(Rpc), .Depth(Depth)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .pc_o             (pc)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int lat        = 1;
  int rel_cyc    = 0;
  int acc_total  = 0;
  int pop_total  = 0;

  logic [63:0] mq_addr [$];
  int          mq_due  [$];
  logic [63:0] acc_addr [$];
  logic [63:0] got_pc [$];
  logic [31:0] got_instr [$];
  int          got_cyc [$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  // Memory model (in-order, fixed latency) and handshake monitor.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && req_valid && req_ready) begin
      mq_addr.push_back(req_addr);
      mq_due.push_back(cyc + lat - 1);
      acc_addr.push_back(req_addr);
      acc_total = acc_total + 1;
    end
    if (!rst && instr_valid && instr_ready) begin
      got_pc.push_back(pc);
      got_instr.push_back(instr);
      got_cyc.push_back(cyc);
      pop_total = pop_total + 1;
    end
    #1;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_pc.delete();
    got_instr.delete();
    got_cyc.delete();
    acc_addr.delete();
  endtask

  task automatic quiesce();
    req_ready   = 1'b0;
    instr_ready = 1'b1;
    tick(10);
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    tick(3);
    @(negedge clk);
    compared++; if (req_valid !== 1'b0) begin mismatched++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    compared++; if (req_addr !== Rpc) begin mismatched++; $display("FAIL reset_req_addr: got %h want %h", req_addr, Rpc); end
    tick(1);
    rst = 1'b0;
    rel_cyc = cyc;
    @(negedge clk);
    compared++; if (req_valid !== 1'b1) begin mismatched++; $display("FAIL first_req_valid: got %b want 1", req_valid); end
    compared++; if (req_addr !== Rpc) begin mismatched++; $display("FAIL first_req_addr: got %h want %h", req_addr, Rpc); end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    tick(12);
    compared++; if (got_pc.size() < 8) begin mismatched++; $display("FAIL stream_count: got %0d want >=8", got_pc.size()); end
    for (int i = 0; i < 8; i++) begin
      e = Rpc + 64'(4 * i);
      if (i < got_pc.size()) begin
        compared++; if (got_pc[i] !== e) begin mismatched++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got_pc[i], e); end
        compared++; if (got_instr[i] !== mem_word(e)) begin mismatched++; $display("FAIL stream_instr[%0d]: got %h want %h", i, got_instr[i], mem_word(e)); end
        compared++; if (got_cyc[i] !== rel_cyc + 3 + i) begin mismatched++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, got_cyc[i], rel_cyc + 3 + i); end
      end
      if (i < acc_addr.size()) begin
        compared++; if (acc_addr[i] !== e) begin mismatched++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, acc_addr[i], e); end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [63:0] e;
    instr_ready = 1'b0;
    base = pop_total;
    tick(10);
    @(negedge clk);
    e = Rpc + 64'(4 * base);
    compared++; if (pop_total !== base) begin mismatched++; $display("FAIL bp_no_pop: got %0d want %0d", pop_total, base); end
    compared++; if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL bp_instr_valid: got %b want 1", instr_valid); end
    compared++; if (req_valid !== 1'b0) begin mismatched++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
    compared++; if (acc_total - pop_total !== Depth) begin mismatched++; $display("FAIL bp_held_words: got %0d want %0d", acc_total - pop_total, Depth); end
    compared++; if (pc !== e) begin mismatched++; $display("FAIL bp_head_pc: got %h want %h", pc, e); end
    compared++; if (instr !== mem_word(e)) begin mismatched++; $display("FAIL bp_head_instr: got %h want %h", instr, mem_word(e)); end
    instr_ready = 1'b1;
    clear_logs();
    tick(12);
    compared++; if (got_pc.size() < 10) begin mismatched++; $display("FAIL bp_release_count: got %0d want >=10", got_pc.size()); end
    for (int i = 0; i < 10; i++) begin
      e = Rpc + 64'(4 * (base + i));
      if (i < got_pc.size()) begin
        compared++; if (got_pc[i] !== e) begin mismatched++; $display("FAIL bp_pc[%0d]: got %h want %h", i, got_pc[i], e); end
        compared++; if (got_instr[i] !== mem_word(e)) begin mismatched++; $display("FAIL bp_instr[%0d]: got %h want %h", i, got_instr[i], mem_word(e)); end
      end
    end
  endtask

  // Shared tail of the redirect scenarios: delivered stream must start exactly at tgt.
  task automatic check_stream_from(input string name, input logic [63:0] tgt, input int n);
    logic [63:0] e;
    compared++; if (got_pc.size() < n) begin mismatched++; $display("FAIL %s_count: got %0d want >=%0d", name, got_pc.size(), n); end
    if (acc_addr.size() > 0) begin
      compared++; if (acc_addr[0] !== tgt) begin mismatched++; $display("FAIL %s_req0: got %h want %h", name, acc_addr[0], tgt); end
    end
    for (int i = 0; i < n; i++) begin
      e = tgt + 64'(4 * i);
      if (i < got_pc.size()) begin
        compared++; if (got_pc[i] !== e) begin mismatched++; $display("FAIL %s_pc[%0d]: got %h want %h", name, i, got_pc[i], e); end
        compared++; if (got_instr[i] !== mem_word(e)) begin mismatched++; $display("FAIL %s_instr[%0d]: got %h want %h", name, i, got_instr[i], mem_word(e)); end
      end
    end
  endtask

  task automatic test_redirect();
    int acc0;
    quiesce();
    lat = 3;
    acc0 = acc_total;
    req_ready = 1'b1;
    tick(2);
    compared++; if (acc_total - acc0 !== 2) begin mismatched++; $display("FAIL rd_outstanding_setup: got %0d want 2", acc_total - acc0); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1002;
    clear_logs();
    @(negedge clk);
    compared++; if (req_valid !== 1'b0) begin mismatched++; $display("FAIL rd_req_valid: got %b want 0", req_valid); end
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL rd_instr_valid: got %b want 0", instr_valid); end
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    compared++; if (req_valid !== 1'b1) begin mismatched++; $display("FAIL rd_next_req_valid: got %b want 1", req_valid); end
    compared++; if (req_addr !== 64'h1000) begin mismatched++; $display("FAIL rd_next_req_addr: got %h want 1000", req_addr); end
    tick(14);
    check_stream_from("rd", 64'h1000, 4);
  endtask

  task automatic test_redirect_rsp();
    quiesce();
    lat = 2;
    req_ready = 1'b1;
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    clear_logs();
    @(negedge clk);
    compared++; if (req_valid !== 1'b0) begin mismatched++; $display("FAIL rr_req_valid: got %b want 0", req_valid); end
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL rr_instr_valid: got %b want 0", instr_valid); end
    tick(1);
    redirect_valid = 1'b0;
    tick(12);
    check_stream_from("rr", 64'h4000, 4);
  endtask

  task automatic test_double_redirect();
    tick(6);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    @(negedge clk);
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL dr_first_instr_valid: got %b want 0", instr_valid); end
    compared++; if (req_valid !== 1'b0) begin mismatched++; $display("FAIL dr_first_req_valid: got %b want 0", req_valid); end
    tick(1);
    redirect_pc = 64'h3000;
    clear_logs();
    @(negedge clk);
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL dr_second_instr_valid: got %b want 0", instr_valid); end
    tick(1);
    redirect_valid = 1'b0;
    tick(16);
    check_stream_from("dr", 64'h3000, 6);
  endtask

  task automatic test_wrap();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    compared++; if (req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin mismatched++; $display("FAIL wrap_req_addr: got %h want fffffffffffffffc", req_addr); end
    tick(10);
    if (acc_addr.size() > 1) begin
      compared++; if (acc_addr[1] !== 64'h0) begin mismatched++; $display("FAIL wrap_req1: got %h want 0", acc_addr[1]); end
    end
    check_stream_from("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 3);
  endtask

  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rsp();
    test_double_redirect();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
